// File: rtl/spi_mem_responder_pkg.sv
// Shared constants for the SPI memory responder: command opcodes, address
// frame length and the FSM state encoding.
package spi_mem_pkg;

    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_WRITE = 8'h02;
    localparam int         ADDR_BITS = 24;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_CMD        = 3'd1;
    localparam logic [2:0] ST_ADDR       = 3'd2;
    localparam logic [2:0] ST_DATA_READ  = 3'd3;
    localparam logic [2:0] ST_DATA_WRITE = 3'd4;
    localparam logic [2:0] ST_IGNORE     = 3'd5;

endpackage

// File: rtl/spi_mem_responder_if.sv
// SPI pin bundle between a CPU master port and one memory responder.
interface spi_mem_if;

    logic sclk;
    logic mosi;
    logic cs_n;
    logic miso;
    logic miso_oe;

    modport master (output sclk, output mosi, output cs_n, input miso, input miso_oe);
    modport slave  (input sclk, input mosi, input cs_n, output miso, output miso_oe);

endinterface

// File: rtl/spi_mem_responder_edge_sync.sv
// Brings the asynchronous SPI pins into clk: 2-flop synchronizers plus
// registered sclk edge pulses (3 clk from pin to pulse).
module spi_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic sclk,
    input  logic mosi,
    input  logic cs_n,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic mosi_s,
    output logic cs_n_s
);

    logic [1:0] sclk_ff;
    logic [1:0] mosi_ff;
    logic [1:0] cs_ff;
    logic       sclk_d;

    // cs_n resets low so a select already asserted at reset release is not
    // mistaken for a new frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_ff   <= '0;
            mosi_ff   <= '0;
            cs_ff     <= '0;
            sclk_d    <= 1'b0;
            sclk_rise <= 1'b0;
            sclk_fall <= 1'b0;
            mosi_s    <= 1'b0;
        end else begin
            sclk_ff   <= {sclk_ff[0], sclk};
            mosi_ff   <= {mosi_ff[0], mosi};
            cs_ff     <= {cs_ff[0], cs_n};
            sclk_d    <= sclk_ff[1];
            sclk_rise <= sclk_ff[1] & ~sclk_d;
            sclk_fall <= ~sclk_ff[1] & sclk_d;
            mosi_s    <= mosi_ff[1];
        end
    end

    assign cs_n_s = cs_ff[1];

endmodule

// File: rtl/spi_mem_responder.sv
// SPI memory responder: decodes READ (03) / WRITE (02) frames with a 24-bit
// address and streams bytes to/from an internal array; backdoor port for preload.
//
// state         | meaning
// IDLE          | waiting for cs_n to fall
// CMD           | shifting in the 8-bit command
// ADDR          | shifting in the 24-bit address
// DATA_READ     | streaming mem bytes out on miso
// DATA_WRITE    | assembling bytes from mosi and writing mem
// IGNORE        | unknown command, drop traffic until cs_n rises
module spi_mem_responder
    import spi_mem_pkg::*;
#(
    parameter int DEPTH = 4096,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    spi_mem_if.slave        spi,
    input  logic            bd_we,
    input  logic [AW-1:0]   bd_addr,
    input  logic [7:0]      bd_wdata,
    output logic [7:0]      bd_rdata,
    output logic            busy
);

    logic       sclk_rise;
    logic       sclk_fall;
    logic       mosi_s;
    logic       cs_n_s;
    logic       cs_prev;
    logic       cs_fall;
    logic       cs_rise;

    logic [2:0]    state;
    logic [2:0]    state_next;
    logic [4:0]    bit_cnt;
    logic [6:0]    shift_in;
    logic [7:0]    rx_byte;
    logic [7:0]    tx_sh;
    logic          miso_q;
    logic          miso_oe_c;
    logic          rd_cmd;
    logic [AW-1:0] addr;
    logic [AW-1:0] addr_next;
    logic [AW-1:0] addr_inc;
    logic          byte_last;
    logic          addr_last;
    logic          spi_we;

    logic [7:0] mem [DEPTH];

    spi_edge_sync u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .sclk      (spi.sclk),
        .mosi      (spi.mosi),
        .cs_n      (spi.cs_n),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .mosi_s    (mosi_s),
        .cs_n_s    (cs_n_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cs_prev <= 1'b0;
        else        cs_prev <= cs_n_s;
    end

    assign cs_fall   = cs_prev & ~cs_n_s;
    assign cs_rise   = ~cs_prev & cs_n_s;
    assign rx_byte   = {shift_in, mosi_s};
    assign addr_next = {addr[AW-2:0], mosi_s};
    assign addr_inc  = addr + AW'(1);
    assign byte_last = (bit_cnt == 5'd7);
    assign addr_last = (bit_cnt == 5'(ADDR_BITS - 1));
    assign spi_we    = (state == ST_DATA_WRITE) && sclk_rise && byte_last && !cs_rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (state != ST_IDLE && cs_rise) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:
                    if (cs_fall) state_next = ST_CMD;
                ST_CMD:
                    if (sclk_rise && byte_last)
                        state_next = (rx_byte == CMD_READ || rx_byte == CMD_WRITE) ? ST_ADDR : ST_IGNORE;
                ST_ADDR:
                    if (sclk_rise && addr_last)
                        state_next = rd_cmd ? ST_DATA_READ : ST_DATA_WRITE;
                ST_DATA_READ, ST_DATA_WRITE, ST_IGNORE: ;
                default:
                    state_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        busy      = (state != ST_IDLE);
        miso_oe_c = (state == ST_DATA_READ) && !cs_n_s;
        spi.miso_oe = miso_oe_c;
        spi.miso    = miso_oe_c ? miso_q : 1'b0;
    end

    // The next read byte is fetched on the last rise of the previous byte so
    // its MSB is ready for the very next fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt  <= '0;
            shift_in <= '0;
            tx_sh    <= '0;
            miso_q   <= 1'b0;
            rd_cmd   <= 1'b0;
            addr     <= '0;
        end else if (state == ST_IDLE || cs_rise) begin
            bit_cnt <= '0;
            miso_q  <= 1'b0;
        end else if (sclk_rise) begin
            bit_cnt <= bit_cnt + 5'd1;
            case (state)
                ST_CMD: begin
                    shift_in <= rx_byte[6:0];
                    if (byte_last) begin
                        bit_cnt <= '0;
                        rd_cmd  <= (rx_byte == CMD_READ);
                    end
                end
                ST_ADDR: begin
                    addr <= addr_next;
                    if (addr_last) begin
                        bit_cnt <= '0;
                        tx_sh   <= mem[addr_next];
                    end
                end
                ST_DATA_READ: begin
                    if (byte_last) begin
                        bit_cnt <= '0;
                        addr    <= addr_inc;
                        tx_sh   <= mem[addr_inc];
                    end
                end
                ST_DATA_WRITE: begin
                    shift_in <= rx_byte[6:0];
                    if (byte_last) begin
                        bit_cnt <= '0;
                        addr    <= addr_inc;
                    end
                end
                default: bit_cnt <= bit_cnt;
            endcase
        end else if (sclk_fall && state == ST_DATA_READ) begin
            miso_q <= tx_sh[7];
            tx_sh  <= {tx_sh[6:0], 1'b0};
        end
    end

    // SPI write is applied last so it wins a same-address backdoor collision.
    always_ff @(posedge clk) begin
        if (bd_we)  mem[bd_addr] <= bd_wdata;
        if (spi_we) mem[addr]    <= rx_byte;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bd_rdata <= '0;
        else        bd_rdata <= mem[bd_addr];
    end

endmodule

// File: tb/tb_spi_mem_responder.sv
// Self-checking bench for spi_mem_responder: scoreboard queue of expected
// bytes, filled from a bench-side memory model and drained as data arrives.
module tb_spi_mem_responder;

    localparam int DEPTH = 4096;
    localparam int AW    = 12;
    localparam int HALF  = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          bd_we = 1'b0;
    logic [AW-1:0] bd_addr = '0;
    logic [7:0]    bd_wdata = '0;
    logic [7:0]    bd_rdata;
    logic          busy;

    logic [7:0] model [DEPTH];
    logic [7:0] exp_q [$];
    int errors = 0;
    int checks = 0;

    spi_mem_if spi ();

    spi_mem_responder #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .spi      (spi),
        .bd_we    (bd_we),
        .bd_addr  (bd_addr),
        .bd_wdata (bd_wdata),
        .bd_rdata (bd_rdata),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bd_write(input logic [AW-1:0] a, input logic [7:0] d);
        bd_addr  = a;
        bd_wdata = d;
        bd_we    = 1'b1;
        wait_clk(1);
        bd_we    = 1'b0;
        model[a] = d;
    endtask

    task automatic bd_read(input logic [AW-1:0] a, output logic [7:0] d);
        bd_addr = a;
        wait_clk(1);
        d = bd_rdata;
    endtask

    task automatic spi_bit(input logic b, output logic r);
        spi.mosi = b;
        wait_clk(HALF);
        spi.sclk = 1'b1;
        r = spi.miso;
        wait_clk(HALF);
        spi.sclk = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(tx[i], r);
            rx[i] = r;
        end
    endtask

    task automatic spi_begin();
        spi.cs_n = 1'b0;
        wait_clk(6);
    endtask

    task automatic spi_end();
        wait_clk(4);
        spi.cs_n = 1'b1;
        wait_clk(6);
    endtask

    task automatic spi_header(input logic [7:0] cmd, input logic [23:0] a);
        logic [7:0] rx;
        spi_byte(cmd, rx);
        spi_byte(a[23:16], rx);
        spi_byte(a[15:8], rx);
        spi_byte(a[7:0], rx);
    endtask

    task automatic test_reset();
        wait_clk(3);
        checks++; if (spi.miso !== 1'b0) begin errors++; $display("FAIL reset_miso: got %b expected 0", spi.miso); end
        checks++; if (spi.miso_oe !== 1'b0) begin errors++; $display("FAIL reset_miso_oe: got %b expected 0", spi.miso_oe); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (bd_rdata !== 8'h00) begin errors++; $display("FAIL reset_bd_rdata: got %h expected 00", bd_rdata); end
        rst_n = 1'b1;
        wait_clk(5);
    endtask

    task automatic test_read();
        logic [7:0] rx, exp;
        bd_write(12'h010, 8'h13);
        bd_write(12'h011, 8'h05);
        bd_write(12'h012, 8'h50);
        bd_write(12'h013, 8'h00);
        for (int i = 'h10; i <= 'h13; i++) exp_q.push_back(model[i]);
        spi_begin();
        spi_byte(8'h03, rx);
        checks++; if (spi.miso_oe !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL read_cmd_phase: got oe=%b busy=%b expected oe=0 busy=1", spi.miso_oe, busy); end
        spi_byte(8'h00, rx);
        spi_byte(8'h00, rx);
        spi_byte(8'h10, rx);
        checks++; if (spi.miso_oe !== 1'b1) begin errors++; $display("FAIL read_oe_data: got %b expected 1", spi.miso_oe); end
        for (int i = 0; i < 4; i++) begin
            spi_byte(8'h00, rx);
            exp = exp_q.pop_front();
            checks++; if (rx !== exp) begin errors++; $display("FAIL read_byte%0d: got %h expected %h", i, rx, exp); end
        end
        spi_end();
        checks++; if (spi.miso_oe !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL read_after_cs: got oe=%b busy=%b expected 0 0", spi.miso_oe, busy); end
    endtask

    task automatic test_write();
        logic [7:0] rx, got, exp;
        bd_write(12'h022, 8'h77);
        spi_begin();
        spi_header(8'h02, 24'h000020);
        spi_byte(8'hAB, rx);
        spi_byte(8'hCD, rx);
        spi_end();
        model[12'h020] = 8'hAB;
        model[12'h021] = 8'hCD;
        for (int i = 'h20; i <= 'h22; i++) exp_q.push_back(model[i]);
        for (int i = 'h20; i <= 'h22; i++) begin
            bd_read(AW'(i), got);
            exp = exp_q.pop_front();
            checks++; if (got !== exp) begin errors++; $display("FAIL write_mem_%0h: got %h expected %h", i, got, exp); end
        end
    endtask

    task automatic test_wrap();
        logic [7:0] rx, got, exp;
        spi_begin();
        spi_header(8'h02, 24'h000FFF);
        spi_byte(8'h11, rx);
        spi_byte(8'h22, rx);
        spi_end();
        model[12'hFFF] = 8'h11;
        model[12'h000] = 8'h22;
        exp_q.push_back(model[12'hFFF]);
        bd_read(12'hFFF, got);
        exp = exp_q.pop_front();
        checks++; if (got !== exp) begin errors++; $display("FAIL wrap_mem_fff: got %h expected %h", got, exp); end
        exp_q.push_back(model[12'h000]);
        bd_read(12'h000, got);
        exp = exp_q.pop_front();
        checks++; if (got !== exp) begin errors++; $display("FAIL wrap_mem_000: got %h expected %h", got, exp); end
        exp_q.push_back(model[12'hFFF]);
        exp_q.push_back(model[12'h000]);
        spi_begin();
        spi_header(8'h03, 24'h001FFF);
        for (int i = 0; i < 2; i++) begin
            spi_byte(8'h00, rx);
            exp = exp_q.pop_front();
            checks++; if (rx !== exp) begin errors++; $display("FAIL wrap_alias_read%0d: got %h expected %h", i, rx, exp); end
        end
        spi_end();
    endtask

    task automatic test_ignore();
        logic [7:0] rx, got, exp;
        spi_begin();
        spi_byte(8'h9F, rx);
        checks++; if (busy !== 1'b1 || spi.miso_oe !== 1'b0) begin errors++; $display("FAIL ignore_state: got busy=%b oe=%b expected 1 0", busy, spi.miso_oe); end
        spi_byte(8'h00, rx);
        spi_byte(8'h00, rx);
        spi_byte(8'h10, rx);
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(8'h00);
            spi_byte(8'hFF, rx);
            exp = exp_q.pop_front();
            checks++; if (rx !== exp) begin errors++; $display("FAIL ignore_miso%0d: got %h expected %h", i, rx, exp); end
        end
        spi_end();
        exp_q.push_back(model[12'h010]);
        bd_read(12'h010, got);
        exp = exp_q.pop_front();
        checks++; if (got !== exp) begin errors++; $display("FAIL ignore_mem: got %h expected %h", got, exp); end
        exp_q.push_back(model[12'h010]);
        spi_begin();
        spi_header(8'h03, 24'h000010);
        spi_byte(8'h00, rx);
        exp = exp_q.pop_front();
        checks++; if (rx !== exp) begin errors++; $display("FAIL ignore_next_read: got %h expected %h", rx, exp); end
        spi_end();
    endtask

    task automatic test_partial_write();
        logic [7:0] rx, got, exp;
        logic r;
        bd_write(12'h030, 8'h5A);
        spi_begin();
        spi_header(8'h02, 24'h000030);
        for (int i = 0; i < 5; i++) spi_bit(1'b1, r);
        spi.cs_n = 1'b1;
        wait_clk(2);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL partial_busy_2clk: got %b expected 1", busy); end
        wait_clk(1);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL partial_idle_3clk: got %b expected 0", busy); end
        wait_clk(6);
        exp_q.push_back(model[12'h030]);
        bd_read(12'h030, got);
        exp = exp_q.pop_front();
        checks++; if (got !== exp) begin errors++; $display("FAIL partial_no_write: got %h expected %h", got, exp); end
        rx = got;
    endtask

    task automatic test_reset_mid_read();
        logic [7:0] rx, got, exp;
        logic r;
        spi_begin();
        spi_header(8'h03, 24'h000012);
        spi_bit(1'b0, r);
        wait_clk(6);
        checks++; if (spi.miso !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL midread_pre: got miso=%b busy=%b expected 1 1", spi.miso, busy); end
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if (spi.miso !== 1'b0 || busy !== 1'b0 || spi.miso_oe !== 1'b0) begin errors++; $display("FAIL midread_async_reset: got miso=%b busy=%b oe=%b expected 0 0 0", spi.miso, busy, spi.miso_oe); end
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(10);
        spi_byte(8'h03, rx);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midread_cs_held_low: got busy=%b expected 0", busy); end
        spi.cs_n = 1'b1;
        wait_clk(6);
        for (int i = 'h10; i <= 'h13; i++) exp_q.push_back(model[i]);
        for (int i = 'h10; i <= 'h13; i++) begin
            bd_read(AW'(i), got);
            exp = exp_q.pop_front();
            checks++; if (got !== exp) begin errors++; $display("FAIL midread_mem_%0h: got %h expected %h", i, got, exp); end
        end
        exp_q.push_back(model[12'h012]);
        spi_begin();
        spi_header(8'h03, 24'h000012);
        spi_byte(8'h00, rx);
        exp = exp_q.pop_front();
        checks++; if (rx !== exp) begin errors++; $display("FAIL midread_recover: got %h expected %h", rx, exp); end
        spi_end();
    endtask

    task automatic test_collision();
        logic [7:0] got, exp;
        logic [7:0] tx;
        logic r;
        tx = 8'hAA;
        spi_begin();
        spi_header(8'h02, 24'h000040);
        for (int i = 7; i >= 1; i--) spi_bit(tx[i], r);
        spi.mosi = tx[0];
        wait_clk(HALF);
        spi.sclk = 1'b1;
        wait_clk(3);
        bd_addr  = 12'h040;
        bd_wdata = 8'h55;
        bd_we    = 1'b1;
        wait_clk(1);
        bd_we    = 1'b0;
        wait_clk(HALF - 4);
        spi.sclk = 1'b0;
        spi_end();
        model[12'h040] = 8'hAA;
        exp_q.push_back(model[12'h040]);
        bd_read(12'h040, got);
        exp = exp_q.pop_front();
        checks++; if (got !== exp) begin errors++; $display("FAIL collision_spi_wins: got %h expected %h", got, exp); end
    endtask

    initial begin
        spi.sclk = 1'b0;
        spi.mosi = 1'b0;
        spi.cs_n = 1'b1;
        test_reset();
        test_read();
        test_write();
        test_wrap();
        test_ignore();
        test_partial_write();
        test_reset_mid_read();
        test_collision();
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_mem_responder.md
# spi_mem_responder

SPI memory responder that models the external program/data memory the rv32e CPU reaches through its SPI master port (sclk, mosi, miso, chip selects). The block decodes READ/WRITE command frames and auto-increments through a byte-addressed internal array, shifting read data back on miso. One instance is placed per CPU chip select: cs1 is the instruction/flash side and cs2 is the data/RAM side. A backdoor port lets the bench or a loader preload and inspect contents.

## Interface
- DEPTH, 4096: bytes of storage; must be a power of two, ≤ 2^24.
- AW, $clog2(DEPTH): internal address width.
- clk  input  1  system clock; same clock as the CPU.
- rst_n  input  1  reset; asynchronous, active-low.
- sclk  input  1  SPI clock from the master; idles low; mode 0.
- mosi  input  1  master-out data.
- cs_n  input  1  chip select, active-low; wire to the CPU's cs1 or cs2.
- miso  output  1  responder-out data; 0 when not driving.
- miso_oe  output  1  high while in DATA_READ with cs_n low.
- bd_we  input  1  backdoor write strobe.
- bd_addr  input  AW  backdoor address.
- bd_wdata  input  8  backdoor write byte.
- bd_rdata  output  8  registered read of mem[bd_addr]; 1-cycle latency.
- busy  output  1  high whenever the state is not IDLE.

## Operation
- sclk, mosi and cs_n pass through a 2-flop synchronizer. Rise and fall events are detected on the synchronized sclk.
- Rise event: sample mosi into the shift register, MSB first. Fall event: update miso.
- States are IDLE, CMD, ADDR, DATA_READ, DATA_WRITE and IGNORE.
- IDLE -> CMD when synchronized cs_n falls. The bit counter clears.
- CMD collects 8 bits:
  - 0x03 -> ADDR, read.
  - 0x02 -> ADDR, write.
  - Any other value -> IGNORE.
- ADDR collects 24 bits, MSB first. Only the low AW bits are kept; upper bits are ignored, so the address aliases modulo DEPTH. After the 24th bit the state moves to DATA_READ or DATA_WRITE.
- DATA_READ:
  - mem[addr] loads into the output shift register on the 24th address rise event.
  - Bit 7 drives miso on the following fall event. Each later fall event shifts the next bit out.
  - After every 8 bits, addr increments and the next byte loads.
- DATA_WRITE:
  - On the 8th rise event of each byte, mem[addr] is written with the assembled byte, then addr increments.
- Address wrap: DEPTH-1 increments to 0.
- IGNORE drops all traffic until cs_n rises.
- cs_n rising in any state returns to IDLE.
  - A partially received write byte is discarded.
  - A partial command or address leaves memory untouched.
- Transfers stream with no length limit. The CPU uses 1, 2 or 4 data bytes; byte 0 is the first byte on the wire.
- Backdoor: bd_we writes at any time. If it coincides with an SPI write to the same address in the same cycle, the SPI write wins.
- Memory contents are not reset. Reset clears the state, counters, shift registers and outputs.

## Timing
- Reset values: miso = 0, miso_oe = 0, busy = 0, bd_rdata = 0, state = IDLE.
- Synchronizer plus edge detect adds 3 clk of latency from a pin transition to the internal event.
- miso changes 1 clk after the fall event, i.e. 4 clk after the sclk pin falls.
- Minimum sclk half-period is 4 clk. The master must hold sclk low or high for at least 4 clk.
- Write commit: mem is updated on the clk edge after the 8th rise event of a byte.
- cs_n must be high for at least 3 clk between frames so it is seen.
- A reset asserted mid-frame aborts immediately. After release, the block waits for the next cs_n falling edge; if cs_n is already low at release, it sits in IDLE until cs_n goes high and then low again.

## Structure
- Package spi_mem_pkg holds:
  - localparams CMD_READ = 8'h03 and CMD_WRITE = 8'h02;
  - ADDR_BITS = 24;
  - the state encoding as 3-bit localparams.
- Sub-module spi_edge_sync: 2-flop synchronizer for sclk, mosi and cs_n, plus registered sclk_rise and sclk_fall pulses and synchronized cs_n. Its reset is asynchronous and active-low.
- The memory array is a plain reg array with no reset.

## Test plan
- Preload via backdoor mem[0x10..0x13] = 0x13,0x05,0x50,0x00. Send frame 03 000010 and clock 32 data bits -> miso returns 0x13,0x05,0x50,0x00 in order; miso_oe is high only during the data phase.
- Send frame 02 000020 AB CD -> backdoor reads of 0x20 and 0x21 give 0xAB and 0xCD; 0x22 is unchanged.
- Wrap, with DEPTH = 4096: write 11 22 starting at address 0x000FFF -> mem[0xFFF] = 0x11 and mem[0x000] = 0x22. Address 0x001FFF aliases to 0xFFF.
- Send command 0x9F -> the block enters IGNORE, miso stays 0 and memory is untouched. The next 03 frame works normally.
- Raise cs_n after 5 bits of a write data byte -> no write occurs and state = IDLE 3 clk later. Assert rst_n low mid-read -> miso = 0 and busy = 0 immediately (asynchronously), and memory contents are preserved.
- Hit the same address with backdoor write 0x55 and SPI write 0xAA in the same cycle -> mem = 0xAA.
